// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the ALU execute stage: MIPS R-type funct codes,
// ALU operation encodings and the default datapath width.
package alu_exec_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluop_t;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT with signed overflow, carry
// (borrow on subtract) and zero flags.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Zero
);
  import alu_exec_stage_pkg::*;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           slt;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  // Differing signs decide directly; otherwise the difference sign is exact.
  assign slt  = (A[WIDTH-1] != B[WIDTH-1]) ? A[WIDTH-1] : diff[WIDTH-1];

  always_comb begin
    Result   = '0;
    Overflow = 1'b0;
    CarryOut = 1'b0;
    case (ALUop)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_ADD: begin
        Result   = sum[WIDTH-1:0];
        CarryOut = sum[WIDTH];
        Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        Result   = diff[WIDTH-1:0];
        CarryOut = diff[WIDTH];
        Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SLT: Result = {{(WIDTH-1){1'b0}}, slt};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage pipelined execute wrapper around alu: operand register (S1),
// output register (S2), valid/ready handshake, trap/illegal flags, op counter.
module alu_exec_stage #(
  parameter int unsigned DATA_WIDTH = alu_exec_stage_pkg::DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_funct,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [4:0]            in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_dest,
  output logic                  out_wen,
  output logic                  out_ovf_trap,
  output logic                  out_illegal,
  output logic                  out_carry,
  output logic                  out_zero,
  output logic [CNT_WIDTH-1:0]  op_count
);
  import alu_exec_stage_pkg::*;

  aluop_t dec_op;
  logic   dec_trap_en;
  logic   dec_illegal;

  logic                  s1_valid_q, s1_valid_d;
  aluop_t                s1_op_q;
  logic                  s1_trap_en_q;
  logic                  s1_illegal_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
  logic [4:0]            s1_dest_q;

  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_result_q, s2_result_d;
  logic [4:0]            s2_dest_q;
  logic                  s2_wen_q, s2_wen_d;
  logic                  s2_trap_q, s2_trap_d;
  logic                  s2_illegal_q;
  logic                  s2_carry_q, s2_carry_d;
  logic                  s2_zero_q, s2_zero_d;

  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

  logic                  alu_ovf, alu_carry, alu_zero;
  logic [DATA_WIDTH-1:0] alu_result;

  logic s2_load, in_fire, s2_fire, out_fire;

  always_comb begin
    dec_op      = ALU_AND;
    dec_trap_en = 1'b0;
    dec_illegal = 1'b0;
    case (in_funct)
      FUNCT_ADD:  begin dec_op = ALU_ADD; dec_trap_en = 1'b1; end
      FUNCT_ADDU: dec_op = ALU_ADD;
      FUNCT_SUB:  begin dec_op = ALU_SUB; dec_trap_en = 1'b1; end
      FUNCT_SUBU: dec_op = ALU_SUB;
      FUNCT_AND:  dec_op = ALU_AND;
      FUNCT_OR:   dec_op = ALU_OR;
      FUNCT_SLT:  dec_op = ALU_SLT;
      default:    dec_illegal = 1'b1;
    endcase
  end

  alu #(.WIDTH(DATA_WIDTH)) u_alu (
    .A        (s1_a_q),
    .B        (s1_b_q),
    .ALUop    (s1_op_q),
    .Result   (alu_result),
    .Overflow (alu_ovf),
    .CarryOut (alu_carry),
    .Zero     (alu_zero)
  );

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = resetn && (!s1_valid_q || s2_load);
  assign in_fire  = in_valid && in_ready;
  assign s2_fire  = s1_valid_q && s2_load;
  assign out_fire = s2_valid_q && out_ready;

  assign s1_valid_d = in_fire || (s1_valid_q && !s2_load);
  assign s2_valid_d = s2_fire || (s2_valid_q && !out_ready);
  assign op_count_d = op_count_q + CNT_WIDTH'(1);

  // Illegal ops still flow through the pipe but carry no result or flags.
  assign s2_result_d = s1_illegal_q ? '0 : alu_result;
  assign s2_trap_d   = s1_trap_en_q && alu_ovf;
  assign s2_wen_d    = !s1_illegal_q && !s2_trap_d;
  assign s2_carry_d  = !s1_illegal_q && alu_carry;
  assign s2_zero_d   = !s1_illegal_q && alu_zero;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= ALU_AND;
      s1_trap_en_q <= 1'b0;
      s1_illegal_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_dest_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_dest_q    <= '0;
      s2_wen_q     <= 1'b0;
      s2_trap_q    <= 1'b0;
      s2_illegal_q <= 1'b0;
      s2_carry_q   <= 1'b0;
      s2_zero_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_op_q      <= dec_op;
        s1_trap_en_q <= dec_trap_en;
        s1_illegal_q <= dec_illegal;
        s1_a_q       <= in_a;
        s1_b_q       <= in_b;
        s1_dest_q    <= in_dest;
      end
      if (s2_fire) begin
        s2_result_q  <= s2_result_d;
        s2_dest_q    <= s1_dest_q;
        s2_wen_q     <= s2_wen_d;
        s2_trap_q    <= s2_trap_d;
        s2_illegal_q <= s1_illegal_q;
        s2_carry_q   <= s2_carry_d;
        s2_zero_q    <= s2_zero_d;
      end
      if (out_fire) begin
        op_count_q <= op_count_d;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_dest     = s2_dest_q;
  assign out_wen      = s2_wen_q;
  assign out_ovf_trap = s2_trap_q;
  assign out_illegal  = s2_illegal_q;
  assign out_carry    = s2_carry_q;
  assign out_zero     = s2_zero_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: streaming, backpressure, flags,
// illegal/SLT, counter wrap (CNT_WIDTH=4) and asynchronous reset mid-flight.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_wen, out_ovf_trap, out_illegal, out_carry, out_zero;
  logic [3:0]  op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct     (in_funct),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_dest      (in_dest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dest     (out_dest),
    .out_wen      (out_wen),
    .out_ovf_trap (out_ovf_trap),
    .out_illegal  (out_illegal),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .op_count     (op_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d);
    in_valid = v;
    in_funct = f;
    in_a     = a;
    in_b     = b;
    in_dest  = d;
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        trap;
    logic        wen;
    logic        ill;
    logic        carry;
    logic        zero;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] s_res[4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               funct   a             b             result        trp wen ill cry zro
    vecs[0] = '{6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{6'h21, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{6'h21, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{6'h22, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{6'h23, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{6'h27, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{6'h2A, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{6'h24, 32'h00000005, 32'h0000000A, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{6'h23, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    s_res[0] = 32'd12;
    s_res[1] = 32'hFFFFFFFE;
    s_res[2] = 32'h000000F0;
    s_res[3] = 32'd3;

    resetn    = 1'b0;
    out_ready = 1'b0;
    set_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_op_count", op_count, 0);
    check("reset_out_result", out_result, 0);
    tick();
    tick();
    resetn = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // Back-to-back streaming
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_op(1'b1, 6'h21, 32'd5, 32'd7, 5'd1);
        1: set_op(1'b1, 6'h23, 32'd3, 32'd5, 5'd2);
        2: set_op(1'b1, 6'h24, 32'hF0F0, 32'h0FF0, 5'd3);
        default: set_op(1'b1, 6'h25, 32'd1, 32'd2, 5'd4);
      endcase
      tick();
      if (i == 0) check("stream_latency_no_early_valid", out_valid, 0);
      else begin
        check($sformatf("stream_valid_%0d", i - 1), out_valid, 1);
        check($sformatf("stream_result_%0d", i - 1), out_result, s_res[i-1]);
        check($sformatf("stream_dest_%0d", i - 1), out_dest, i);
      end
      check($sformatf("stream_in_ready_%0d", i), in_ready, 1);
    end
    set_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    tick();
    check("stream_valid_3", out_valid, 1);
    check("stream_result_3", out_result, s_res[3]);
    tick();
    check("stream_drained", out_valid, 0);
    check("stream_op_count", op_count, 4);

    // Backpressure: two buffered, third blocked until out_ready rises
    out_ready = 1'b0;
    set_op(1'b1, 6'h21, 32'd1, 32'd1, 5'd5);
    tick();
    check("bp_ready_after_1", in_ready, 1);
    set_op(1'b1, 6'h21, 32'd2, 32'd2, 5'd6);
    tick();
    set_op(1'b1, 6'h21, 32'd3, 32'd3, 5'd7);
    #1;
    check("bp_ready_full", in_ready, 0);
    tick();
    check("bp_still_blocked", in_ready, 0);
    check("bp_hold_result", out_result, 2);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb_rise", in_ready, 1);
    tick();
    set_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    check("bp_drain_1", out_result, 4);
    tick();
    check("bp_drain_2", out_result, 6);
    check("bp_drain_2_dest", out_dest, 7);
    tick();
    check("bp_empty", out_valid, 0);
    check("bp_op_count", op_count, 7);

    // Flag vectors, one op at a time
    for (int i = 0; i < 10; i++) begin
      set_op(1'b1, vecs[i].funct, vecs[i].a, vecs[i].b, 5'd9);
      tick();
      set_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
      tick();
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_result", i), out_result, vecs[i].res);
      check($sformatf("v%0d_trap", i), out_ovf_trap, vecs[i].trap);
      check($sformatf("v%0d_wen", i), out_wen, vecs[i].wen);
      check($sformatf("v%0d_illegal", i), out_illegal, vecs[i].ill);
      check($sformatf("v%0d_carry", i), out_carry, vecs[i].carry);
      check($sformatf("v%0d_zero", i), out_zero, vecs[i].zero);
      tick();
    end
    check("count_wrap_17", op_count, 1);

    // Reset with both stages full
    out_ready = 1'b0;
    set_op(1'b1, 6'h21, 32'd8, 32'd8, 5'd10);
    tick();
    set_op(1'b1, 6'h21, 32'd9, 32'd9, 5'd11);
    tick();
    set_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_op_count", op_count, 0);
    check("async_rst_result", out_result, 0);
    out_ready = 1'b1;
    tick();
    resetn = 1'b1;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    tick();
    check("no_stale_1", out_valid, 0);
    tick();
    check("no_stale_2", out_valid, 0);
    check("no_stale_count", op_count, 0);

    set_op(1'b1, 6'h21, 32'd10, 32'd20, 5'd12);
    tick();
    set_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
    tick();
    check("post_rst_result", out_result, 30);
    tick();
    check("post_rst_count", op_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Two-stage pipelined execute wrapper around the existing combinational `alu`. Sits between the decode/register-read stage and writeback.
- Accepts R-type operations via valid/ready, decodes MIPS funct to the 3-bit ALUop, and registers operands.
- Drives `alu`, then registers result, flags, destination and write-enable into an output stage with valid/ready backpressure.
- Raises an overflow trap for signed add/sub, flags illegal funct codes, and counts completed operations.

Parameters:
- DATA_WIDTH, 32, operand/result width; must equal the `alu` width.
- CNT_WIDTH, 32, width of the completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  stage can accept this cycle.
- in_funct  input  6  MIPS R-type funct field.
- in_a  input  DATA_WIDTH  operand rs.
- in_b  input  DATA_WIDTH  operand rt.
- in_dest  input  5  destination register number.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  DATA_WIDTH  ALU result; 0 when illegal.
- out_dest  output  5  destination register number.
- out_wen  output  1  writeback enable.
- out_ovf_trap  output  1  signed overflow on ADD/SUB.
- out_illegal  output  1  unsupported funct.
- out_carry  output  1  ALU CarryOut (borrow on subtract).
- out_zero  output  1  ALU Zero.
- op_count  output  CNT_WIDTH  operations delivered downstream.

Behaviour:
- Reset, asynchronous on resetn low:
  - s1_valid = 0, s2_valid = 0.
  - All data registers, including every out_* field, cleared to 0. op_count = 0.
  - in_ready is forced to 0 while resetn is low.
- Reset mid-operation discards all in-flight operations; nothing is delivered and the count does not change.
- funct decode, performed at S1 capture:
  - 0x20 ADD → ADD, trap-capable.
  - 0x21 ADDU → ADD.
  - 0x22 SUB → SUB, trap-capable.
  - 0x23 SUBU → SUB.
  - 0x24 AND → AND.
  - 0x25 OR → OR.
  - 0x2A SLT → SLT.
  - Any other funct → illegal. ALUop is driven to AND, but the result is forced to 0.
- S1 (operand register):
  - Loads {aluop, trap_en, illegal, a, b, dest} on in_valid & in_ready.
  - The `alu` is fed combinationally from S1.
- S2 (output register):
  - Loads when s1_valid & s2_load, where s2_load = !s2_valid | out_ready.
  - Captures:
    - out_result = illegal ? 0 : Result.
    - out_ovf_trap = trap_en & Overflow.
    - out_wen = !illegal & !out_ovf_trap.
    - out_carry = CarryOut, out_zero = Zero, out_dest = dest.
  - When illegal, out_carry and out_zero are forced to 0.
- Handshake:
  - in_ready = resetn & (!s1_valid | s2_load).
  - out_valid = s2_valid.
  - s1_valid next = (in_valid & in_ready) | (s1_valid & !s2_load).
  - s2_valid next = (s1_valid & s2_load) | (s2_valid & !out_ready).
- Latency: an operation accepted at edge k appears with out_valid high after edge k+1. With out_ready held at 1, throughput is 1 op/cycle.
- Data stability: S2 contents stay stable while out_valid & !out_ready. S1 holds while blocked.
- Backpressure: with out_ready low, at most 2 operations are buffered, then in_ready drops. in_ready rises again in the same cycle that out_ready rises; this path is combinational.
- Simultaneous events: accepting into S1 while S1 moves to S2 in the same cycle is legal. Upstream sees no bubble.
- op_count:
  - Increments by 1 on out_valid & out_ready, including trapped and illegal operations.
  - Wraps modulo 2^CNT_WIDTH without a flag.
- Zero reflects the forced-0 result only for legal operations; for illegal operations out_zero = 0 as stated above.

Decomposition:
- Shared package/header holds:
  - FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR, FUNCT_SLT.
  - The ALUop encodings: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
  - DATA_WIDTH.
- One sub-module: the existing `alu`, instantiated unchanged.
- The funct decoder stays inline.

Test Plan:
- Back-to-back streaming: ADDU 5+7, SUBU 3−5, AND F0F0&0FF0, OR 1|2, all with out_ready=1.
  - Results 12, 0xFFFFFFFE, 0x000000F0, 3 appear on 4 consecutive cycles starting 2 cycles after the first in_valid.
  - op_count reaches 4.
- Backpressure: out_ready=0 and 3 ops offered.
  - Two are accepted; in_ready=0 on the third.
  - Raising out_ready drains them in order with no loss or duplication; the third is then accepted.
- Overflow trap:
  - ADD 0x7FFFFFFF+1 → out_ovf_trap=1, out_wen=0, out_result=0x80000000.
  - ADDU with the same operands → trap=0, wen=1.
- Illegal and SLT:
  - funct 0x27 → out_illegal=1, out_result=0, out_wen=0.
  - SLT −1,1 → out_result=1.
  - SLT 1,−1 → out_result=0.
- Reset mid-flight: resetn low with both stages full.
  - out_valid=0 and in_ready=0 immediately (asynchronous), op_count=0.
  - After release, in_ready=1 and no stale result is emitted.
- Counter wrap, with CNT_WIDTH=4: 17 delivered ops → op_count=1.
